// File: rtl/ram_burst_pkg.sv
// Shared types and default sizes for the RAM burst reader and its output buffer.
package ram_burst_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 4;
   localparam int BUF_DEPTH  = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/rd_buf2.sv
// Two-entry FIFO holding words returned by the RAM until the consumer takes them.
module rd_buf2 import ram_burst_pkg::*; #(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic [1:0]        occ_o
);

   logic [DATA_W-1:0] mem_q [BUF_DEPTH];
   logic              wr_ptr_q;
   logic              rd_ptr_q;
   logic [1:0]        occ_q;
   logic              pop_eff;

   assign pop_eff = pop_i && (occ_q != 2'd0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         occ_q    <= 2'd0;
      end else begin
         if (push_i)  wr_ptr_q <= ~wr_ptr_q;
         if (pop_eff) rd_ptr_q <= ~rd_ptr_q;
         occ_q <= occ_q + {1'b0, push_i} - {1'b0, pop_eff};
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   // Storage is not reset, so an empty buffer is forced to present zero.
   assign rdata_o = (occ_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
   assign occ_o   = occ_q;

endmodule

// File: rtl/ram_burst_reader.sv
// Strided burst read sequencer: issues credit-limited RAM reads and streams the words out.
module ram_burst_reader import ram_burst_pkg::*; #(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] stride,
   input  logic              dir,
   input  logic [ADDR_W:0]   len,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_rd,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] stride_q;
   logic              dir_q;
   logic [ADDR_W:0]   rem_q, rem_d;
   logic              inflight_q;
   logic [1:0]        occ;
   logic              pop;
   logic [2:0]        need;
   logic              credit;
   logic              issue;
   logic              accept;
   logic              drain_empty;

   assign pop    = out_valid && out_ready;
   // A pop this cycle frees a slot for the word that lands two cycles from now.
   assign need   = {1'b0, occ} + {2'b00, inflight_q};
   assign credit = need < (3'd2 + {2'b00, pop});
   assign issue  = (state_q == ISSUE) && credit;
   assign accept = (state_q == IDLE) && start && (len != '0);

   assign drain_empty = !inflight_q &&
                        ((occ == 2'd0) || ((occ == 2'd1) && pop));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (start) state_d = (len == '0) ? DONE : ISSUE;
         ISSUE: if (issue && (rem_q == {{ADDR_W{1'b0}}, 1'b1})) state_d = DRAIN;
         DRAIN: if (drain_empty) state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy   = (state_q != IDLE);
      done   = (state_q == DONE);
      ram_rd = issue;
   end

   always_comb begin
      addr_d = addr_q;
      rem_d  = rem_q;
      if (accept) begin
         addr_d = base_addr;
         rem_d  = len;
      end else if (issue) begin
         addr_d = dir_q ? (addr_q - stride_q) : (addr_q + stride_q);
         rem_d  = rem_q - {{ADDR_W{1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q     <= '0;
         stride_q   <= '0;
         dir_q      <= 1'b0;
         rem_q      <= '0;
         inflight_q <= 1'b0;
      end else begin
         addr_q     <= addr_d;
         rem_q      <= rem_d;
         inflight_q <= issue;
         if (accept) begin
            stride_q <= stride;
            dir_q    <= dir;
         end
      end
   end

   assign ram_addr = addr_q;

   rd_buf2 #(.DATA_W(DATA_W)) u_buf (
      .clk     (clk),
      .reset   (reset),
      .push_i  (inflight_q),
      .wdata_i (ram_rdata),
      .pop_i   (pop),
      .rdata_o (out_data),
      .occ_o   (occ)
   );

   assign out_valid = (occ != 2'd0);

endmodule
